// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception/interrupt controller for the M stage of the 5-stage MIPS core.
// Decides in the same cycle whether to take an interrupt or exception (Req), records
// BD/ExcCode/EPC on the taking edge, and services mfc0/mtc0 and eret.
//
// Ports:
//   clk, RESET     clock; synchronous active-high reset
//   M_VPC, M_BD    victim PC and delay-slot flag of the instruction in M
//   M_ExcCode      exception code from M (0 = none)
//   HWInt          level-sensitive hardware interrupt lines
//   cp0_we/addr/wdata  mtc0 commit; cp0_addr also selects the mfc0 read
//   eret           eret commits in M
//   cp0_rdata      combinational mfc0 data (pre-edge value)
//   epc_out        current EPC, the eret target
//   Req            take exception this cycle (flush + redirect)
//   handler_pc     constant exception handler entry
module cp0_exc_ctrl #(
  parameter logic [31:0] HANDLE_START = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic [31:0] M_VPC,
  input  logic        M_BD,
  input  logic [4:0]  M_ExcCode,
  input  logic [5:0]  HWInt,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  input  logic        eret,
  output logic [31:0] cp0_rdata,
  output logic [31:0] epc_out,
  output logic        Req,
  output logic [31:0] handler_pc
);

  localparam logic [4:0] AddrSr    = 5'd12;
  localparam logic [4:0] AddrCause = 5'd13;
  localparam logic [4:0] AddrEpc   = 5'd14;
  localparam logic [4:0] AddrPrid  = 5'd15;

  // Only the architecturally defined fields are stored; every other bit reads 0.
  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic [31:0] sr_val;
  logic [31:0] cause_val;

  // Request logic: EXL masks both sources; an interrupt outranks a simultaneous exception.
  always_comb begin
    int_req = ie_q & ~exl_q & (|(im_q & HWInt));
    exc_req = (M_ExcCode != 5'd0) & ~exl_q;
    Req     = int_req | exc_req;
  end

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    if (Req) begin
      // The faulting instruction is flushed, so any mtc0/eret it carries is dropped.
      exl_d      = 1'b1;
      bd_d       = M_BD;
      exc_code_d = int_req ? 5'd0 : M_ExcCode;
      epc_d      = M_BD ? (M_VPC - 32'd4) : M_VPC;
    end else begin
      if (cp0_we) begin
        if (cp0_addr == AddrSr) begin
          im_d  = cp0_wdata[15:10];
          exl_d = cp0_wdata[1];
          ie_d  = cp0_wdata[0];
        end else if (cp0_addr == AddrEpc) begin
          epc_d = cp0_wdata;
        end
      end
      // eret clears EXL after any same-cycle SR write.
      if (eret) begin
        exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      im_q       <= 6'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= 6'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= HWInt;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  always_comb begin
    sr_val    = {16'd0, im_q, 8'd0, exl_q, ie_q};
    cause_val = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};
    case (cp0_addr)
      AddrSr:    cp0_rdata = sr_val;
      AddrCause: cp0_rdata = cause_val;
      AddrEpc:   cp0_rdata = epc_q;
      AddrPrid:  cp0_rdata = PRID_VAL;
      default:   cp0_rdata = 32'd0;
    endcase
  end

  assign epc_out    = epc_q;
  assign handler_pc = HANDLE_START;

  // Undefined SR bits are write-ignored.
  logic unused_wdata;
  assign unused_wdata = ^{cp0_wdata[31:16], cp0_wdata[9:2]};

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
module tb_cp0_exc_ctrl;

  logic        clk;
  logic        RESET;
  logic [31:0] M_VPC;
  logic        M_BD;
  logic [4:0]  M_ExcCode;
  logic [5:0]  HWInt;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic        eret;
  logic [31:0] cp0_rdata;
  logic [31:0] epc_out;
  logic        Req;
  logic [31:0] handler_pc;

  int checks;
  int failures;

  cp0_exc_ctrl #(
    .HANDLE_START(32'h0000_4180),
    .PRID_VAL    (32'h0001_8000)
  ) dut (
    .clk       (clk),
    .RESET     (RESET),
    .M_VPC     (M_VPC),
    .M_BD      (M_BD),
    .M_ExcCode (M_ExcCode),
    .HWInt     (HWInt),
    .cp0_we    (cp0_we),
    .cp0_addr  (cp0_addr),
    .cp0_wdata (cp0_wdata),
    .eret      (eret),
    .cp0_rdata (cp0_rdata),
    .epc_out   (epc_out),
    .Req       (Req),
    .handler_pc(handler_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    M_VPC     = 32'd0;
    M_BD      = 1'b0;
    M_ExcCode = 5'd0;
    HWInt     = 6'd0;
    cp0_we    = 1'b0;
    cp0_addr  = 5'd0;
    cp0_wdata = 32'd0;
    eret      = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a);
    cp0_addr = a;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    rd(5'd12);
    checks++; if (cp0_rdata !== 32'd0) begin failures++;
      $display("FAIL reset_sr got=%h exp=%h", cp0_rdata, 32'd0); end
    rd(5'd13);
    checks++; if (cp0_rdata !== 32'd0) begin failures++;
      $display("FAIL reset_cause got=%h exp=%h", cp0_rdata, 32'd0); end
    rd(5'd14);
    checks++; if (cp0_rdata !== 32'd0) begin failures++;
      $display("FAIL reset_epc got=%h exp=%h", cp0_rdata, 32'd0); end
    checks++; if (epc_out !== 32'd0) begin failures++;
      $display("FAIL reset_epc_out got=%h exp=%h", epc_out, 32'd0); end
    checks++; if (Req !== 1'b0) begin failures++;
      $display("FAIL reset_req got=%b exp=0", Req); end
    checks++; if (handler_pc !== 32'h0000_4180) begin failures++;
      $display("FAIL handler_pc got=%h exp=%h", handler_pc, 32'h0000_4180); end
  endtask

  task automatic test_masked_irq();
    HWInt = 6'h3F;
    #1;
    checks++; if (Req !== 1'b0) begin failures++;
      $display("FAIL masked_irq_req got=%b exp=0", Req); end
    tick();
    rd(5'd13);
    checks++; if (cp0_rdata !== 32'h0000_FC00) begin failures++;
      $display("FAIL cause_ip got=%h exp=%h", cp0_rdata, 32'h0000_FC00); end
    clear_inputs();
  endtask

  task automatic test_interrupt();
    cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401;
    tick();
    cp0_we = 1'b0;
    rd(5'd12);
    checks++; if (cp0_rdata !== 32'h0000_0401) begin failures++;
      $display("FAIL mtc0_sr got=%h exp=%h", cp0_rdata, 32'h0000_0401); end
    HWInt = 6'h01; M_VPC = 32'h0000_3010;
    #1;
    checks++; if (Req !== 1'b1) begin failures++;
      $display("FAIL irq_req got=%b exp=1", Req); end
    tick();
    HWInt = 6'h00;
    rd(5'd13);
    checks++; if (cp0_rdata !== 32'h0000_0400) begin failures++;
      $display("FAIL irq_cause got=%h exp=%h", cp0_rdata, 32'h0000_0400); end
    rd(5'd12);
    checks++; if (cp0_rdata !== 32'h0000_0403) begin failures++;
      $display("FAIL irq_sr_exl got=%h exp=%h", cp0_rdata, 32'h0000_0403); end
    checks++; if (epc_out !== 32'h0000_3010) begin failures++;
      $display("FAIL irq_epc got=%h exp=%h", epc_out, 32'h0000_3010); end
    HWInt = 6'h01;
    #1;
    checks++; if (Req !== 1'b0) begin failures++;
      $display("FAIL irq_nested_req got=%b exp=0", Req); end
    clear_inputs();
  endtask

  task automatic test_exception_bd();
    do_reset();
    M_ExcCode = 5'd10; M_BD = 1'b1; M_VPC = 32'h0000_3008;
    #1;
    checks++; if (Req !== 1'b1) begin failures++;
      $display("FAIL exc_req got=%b exp=1", Req); end
    tick();
    clear_inputs();
    rd(5'd14);
    checks++; if (cp0_rdata !== 32'h0000_3004) begin failures++;
      $display("FAIL exc_bd_epc got=%h exp=%h", cp0_rdata, 32'h0000_3004); end
    rd(5'd13);
    checks++; if (cp0_rdata !== 32'h8000_0028) begin failures++;
      $display("FAIL exc_bd_cause got=%h exp=%h", cp0_rdata, 32'h8000_0028); end
  endtask

  // Continues from the EXL=1 state left by test_exception_bd.
  task automatic test_nesting_eret();
    cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0403;
    tick();
    cp0_we = 1'b0;
    M_ExcCode = 5'd4; HWInt = 6'h01; M_VPC = 32'h0000_3040;
    #1;
    checks++; if (Req !== 1'b0) begin failures++;
      $display("FAIL nest_req got=%b exp=0", Req); end
    tick();
    M_ExcCode = 5'd0;
    checks++; if (epc_out !== 32'h0000_3004) begin failures++;
      $display("FAIL nest_epc got=%h exp=%h", epc_out, 32'h0000_3004); end
    rd(5'd13);
    checks++; if (cp0_rdata !== 32'h8000_0428) begin failures++;
      $display("FAIL nest_cause got=%h exp=%h", cp0_rdata, 32'h8000_0428); end
    eret = 1'b1;
    #1;
    checks++; if (Req !== 1'b0) begin failures++;
      $display("FAIL eret_cycle_req got=%b exp=0", Req); end
    tick();
    eret = 1'b0;
    rd(5'd12);
    checks++; if (cp0_rdata !== 32'h0000_0401) begin failures++;
      $display("FAIL eret_sr got=%h exp=%h", cp0_rdata, 32'h0000_0401); end
    checks++; if (Req !== 1'b1) begin failures++;
      $display("FAIL eret_pending_req got=%b exp=1", Req); end
    clear_inputs();
  endtask

  task automatic test_simultaneous();
    do_reset();
    M_ExcCode = 5'd12; M_VPC = 32'h0000_3020;
    cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_1234;
    tick();
    clear_inputs();
    checks++; if (epc_out !== 32'h0000_3020) begin failures++;
      $display("FAIL req_vs_mtc0_epc got=%h exp=%h", epc_out, 32'h0000_3020); end
    rd(5'd13);
    checks++; if (cp0_rdata !== 32'h0000_0030) begin failures++;
      $display("FAIL req_vs_mtc0_cause got=%h exp=%h", cp0_rdata, 32'h0000_0030); end
    do_reset();
    M_ExcCode = 5'd12; M_VPC = 32'h0000_3020; eret = 1'b1;
    cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_1234;
    tick();
    clear_inputs();
    rd(5'd12);
    checks++; if (cp0_rdata !== 32'h0000_0002) begin failures++;
      $display("FAIL req_vs_eret_sr got=%h exp=%h", cp0_rdata, 32'h0000_0002); end
    checks++; if (epc_out !== 32'h0000_3020) begin failures++;
      $display("FAIL req_vs_eret_epc got=%h exp=%h", epc_out, 32'h0000_3020); end
    // eret together with mtc0 SR: written value lands, then EXL forced 0.
    cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'hFFFF_FFFF; eret = 1'b1;
    tick();
    clear_inputs();
    rd(5'd12);
    checks++; if (cp0_rdata !== 32'h0000_FC01) begin failures++;
      $display("FAIL eret_mtc0_sr got=%h exp=%h", cp0_rdata, 32'h0000_FC01); end
    // Writes to Cause are ignored.
    rd(5'd13);
    cp0_we = 1'b1; cp0_wdata = 32'hFFFF_FFFF;
    tick();
    clear_inputs();
    rd(5'd13);
    checks++; if (cp0_rdata !== 32'h0000_0030) begin failures++;
      $display("FAIL mtc0_cause_ignored got=%h exp=%h", cp0_rdata, 32'h0000_0030); end
  endtask

  task automatic test_epc_wrap();
    do_reset();
    M_ExcCode = 5'd4; M_BD = 1'b1; M_VPC = 32'h0000_0000;
    tick();
    clear_inputs();
    checks++; if (epc_out !== 32'hFFFF_FFFC) begin failures++;
      $display("FAIL epc_wrap got=%h exp=%h", epc_out, 32'hFFFF_FFFC); end
  endtask

  task automatic test_reset_vs_req();
    do_reset();
    cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401;
    tick();
    clear_inputs();
    HWInt = 6'h01; M_ExcCode = 5'd5; M_VPC = 32'h0000_3100; RESET = 1'b1;
    #1;
    checks++; if (Req !== 1'b1) begin failures++;
      $display("FAIL pre_reset_req got=%b exp=1", Req); end
    tick();
    RESET = 1'b0;
    clear_inputs();
    rd(5'd12);
    checks++; if (cp0_rdata !== 32'd0) begin failures++;
      $display("FAIL rst_req_sr got=%h exp=%h", cp0_rdata, 32'd0); end
    rd(5'd13);
    checks++; if (cp0_rdata !== 32'd0) begin failures++;
      $display("FAIL rst_req_cause got=%h exp=%h", cp0_rdata, 32'd0); end
    checks++; if (epc_out !== 32'd0) begin failures++;
      $display("FAIL rst_req_epc got=%h exp=%h", epc_out, 32'd0); end
    rd(5'd15);
    checks++; if (cp0_rdata !== 32'h0001_8000) begin failures++;
      $display("FAIL prid got=%h exp=%h", cp0_rdata, 32'h0001_8000); end
    rd(5'd3);
    checks++; if (cp0_rdata !== 32'd0) begin failures++;
      $display("FAIL unmapped_read got=%h exp=%h", cp0_rdata, 32'd0); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RESET    = 1'b1;
    clear_inputs();
    test_reset();
    test_masked_irq();
    test_interrupt();
    test_exception_bd();
    test_nesting_eret();
    test_simultaneous();
    test_epc_wrap();
    test_reset_vs_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
